video_frame_capture: RTL and testbench

- Sink-side counterpart of the GPU frame synthesizer: accepts an RGB332 pixel stream with hs/vs/blank timing and writes one frame into an 8-bit VRAM write port.
- Optional integer decimation stores a downscaled copy, e.g. 640x480 into 320x240.
- Sits between a video source (GPU loopback or external RGB332 input) and a VRAM write arbiter.
- CPU arms a capture with `start`; the block signals completion with `done`.

---
 rtl/video_frame_capture_if.sv | 44 ++++
 rtl/video_frame_capture.sv | 191 +++++++++++++++++++
 tb/tb_video_frame_capture.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/video_frame_capture_if.sv
// Bundle of the video input timing/pixel bus, the capture control handshake and
// the VRAM write port used by video_frame_capture.
// Optional feature macro: FRAME_CAPTURE_CHECKSUM_EN adds the 16-bit checksum signal.
// Ports (slave = capture block view):
//   in : hs, vs, blank, r[2:0], g[2:0], b[1:0], start
//   out: busy, done, err, wr_en, wr_addr[ADDR_W-1:0], wr_data[7:0] (+ checksum[15:0])
interface video_frame_capture_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              hs;
  logic              vs;
  logic              blank;
  logic [2:0]        r;
  logic [2:0]        g;
  logic [1:0]        b;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
`ifdef FRAME_CAPTURE_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  // Video source / CPU side
  modport master (
    output hs, vs, blank, r, g, b, start,
    input  busy, done, err, wr_en, wr_addr, wr_data
`ifdef FRAME_CAPTURE_CHECKSUM_EN
    , input checksum
`endif
  );

  // Capture block side
  modport slave (
    input  hs, vs, blank, r, g, b, start,
    output busy, done, err, wr_en, wr_addr, wr_data
`ifdef FRAME_CAPTURE_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface

// File: rtl/video_frame_capture.sv
// Captures one RGB332 frame (optionally decimated by DECIM in x and y) from an
// hs/vs/blank timed pixel stream into an 8-bit VRAM write port.
// Optional feature macro: FRAME_CAPTURE_CHECKSUM_EN (16-bit running sum of written pixels).
// Ports:
//   clk    : pixel clock
//   reset  : synchronous, active-high
//   cap_if : video_frame_capture_if.slave (video in, start/busy/done/err, VRAM write port)
module video_frame_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned DECIM    = 2,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  video_frame_capture_if.slave  cap_if
);
  localparam int unsigned X_W  = $clog2(H_ACTIVE + 1);
  localparam int unsigned Y_W  = $clog2(V_ACTIVE + 1);
  localparam int unsigned PH_W = 2;
  localparam logic [X_W-1:0]  X_END   = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(V_ACTIVE - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic              vs_s1_q, blank_s1_q, vs_prev_q, blank_prev_q;
  logic [7:0]        pix_s1_q;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [PH_W-1:0]   phx_q, phx_d, phy_q, phy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
`ifdef FRAME_CAPTURE_CHECKSUM_EN
  logic [15:0]       chk_q, chk_d;
`endif

  logic vs_fall_c, line_end_c, frame_full_c;

  // Input stage; hs is not needed since line boundaries come from blank edges
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_s1_q      <= 1'b0;
      blank_s1_q   <= 1'b0;
      pix_s1_q     <= 8'h00;
      vs_prev_q    <= 1'b0;
      blank_prev_q <= 1'b0;
    end else begin
      vs_s1_q      <= cap_if.vs;
      blank_s1_q   <= cap_if.blank;
      pix_s1_q     <= {cap_if.r, cap_if.g, cap_if.b};
      vs_prev_q    <= vs_s1_q;
      blank_prev_q <= blank_s1_q;
    end
  end

  assign vs_fall_c    = !vs_s1_q && vs_prev_q;
  assign line_end_c   = blank_s1_q && !blank_prev_q;
  assign frame_full_c = line_end_c && (y_q == Y_LAST);

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      phx_q     <= '0;
      phy_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
`ifdef FRAME_CAPTURE_CHECKSUM_EN
      chk_q     <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      phx_q     <= phx_d;
      phy_q     <= phy_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef FRAME_CAPTURE_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    phx_d     = phx_q;
    phy_d     = phy_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef FRAME_CAPTURE_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cap_if.start) begin
          state_d = WAIT_VS;
          busy_d  = 1'b1;
        end
      end
      WAIT_VS: begin
        x_d       = '0;
        y_d       = '0;
        phx_d     = '0;
        phy_d     = '0;
        addr_d    = '0;
        wr_addr_d = '0;
        if (vs_fall_c) begin
          state_d = CAPTURE;
`ifdef FRAME_CAPTURE_CHECKSUM_EN
          chk_d   = 16'h0000;
`endif
        end
      end
      CAPTURE: begin
        if (!blank_s1_q) begin
          // x saturates at H_ACTIVE so overlong lines are dropped without
          // disturbing the address sequence
          if (x_q < X_END) begin
            if (phx_q == '0 && phy_q == '0) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = pix_s1_q;
              addr_d    = addr_q + ADDR_W'(1);
`ifdef FRAME_CAPTURE_CHECKSUM_EN
              chk_d     = chk_q + 16'(pix_s1_q);
`endif
            end
            x_d   = x_q + X_W'(1);
            phx_d = (phx_q == PH_LAST) ? '0 : phx_q + PH_W'(1);
          end
        end else if (line_end_c) begin
          x_d   = '0;
          phx_d = '0;
          y_d   = y_q + Y_W'(1);
          phy_d = (phy_q == PH_LAST) ? '0 : phy_q + PH_W'(1);
        end
        // A line_end coinciding with vs_fall is counted first
        if (frame_full_c) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (vs_fall_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cap_if.busy    = busy_q;
  assign cap_if.done    = done_q;
  assign cap_if.err     = err_q;
  assign cap_if.wr_en   = wr_en_q;
  assign cap_if.wr_addr = wr_addr_q;
  assign cap_if.wr_data = wr_data_q;
`ifdef FRAME_CAPTURE_CHECKSUM_EN
  assign cap_if.checksum = chk_q;
`endif
endmodule

// File: tb/tb_video_frame_capture.sv
// Self-checking bench: two captures (DECIM=1 and DECIM=2) on one shared stream,
// compared against a frame-level model of which frames get captured and what
// pixels land at which address.
module tb_video_frame_capture;
  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned AW = 6;

  logic       clk = 1'b0;
  logic       rst, hs, vs, blank, st;
  logic [7:0] pix;

  always #5 clk = ~clk;

  video_frame_capture_if #(.ADDR_W(AW)) if1 ();
  video_frame_capture_if #(.ADDR_W(AW)) if2 ();

  assign if1.hs = hs;  assign if1.vs = vs;  assign if1.blank = blank;
  assign if1.r = pix[7:5]; assign if1.g = pix[4:2]; assign if1.b = pix[1:0];
  assign if1.start = st;
  assign if2.hs = hs;  assign if2.vs = vs;  assign if2.blank = blank;
  assign if2.r = pix[7:5]; assign if2.g = pix[4:2]; assign if2.b = pix[1:0];
  assign if2.start = st;

  video_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .reset(rst), .cap_if(if1.slave));
  video_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .ADDR_W(AW)) dut2 (
    .clk(clk), .reset(rst), .cap_if(if2.slave));

  typedef enum {M_IDLE, M_WAIT, M_CAP} mstate_t;
  mstate_t     ms = M_IDLE;
  logic [15:0] exp1[$], exp2[$], got1[$], got2[$];
  int a1, a2, sum1, sum2;
  int n_done1, n_done2, n_err1, n_err2, exp_done_n, exp_err_n;
  int cyc = 0, done_at = -1, err_at = -1, lat_at = -1, rst_at = -1;
  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One pixel clock: sample outputs, run timed checks, then drive the next inputs
  task automatic tick(input logic h, input logic v, input logic bl, input logic [7:0] p,
                      input logic s, input logic r);
    @(negedge clk);
    cyc++;
    if (if1.wr_en) got1.push_back(16'({if1.wr_addr, if1.wr_data}));
    if (if2.wr_en) got2.push_back(16'({if2.wr_addr, if2.wr_data}));
    if (if1.done) n_done1++;
    if (if2.done) n_done2++;
    if (if1.err)  n_err1++;
    if (if2.err)  n_err2++;
    if (cyc == done_at - 1) check_eq("done_early", 32'(if1.done), 32'd0);
    if (cyc == done_at) begin
      check_eq("done1", 32'(if1.done), 32'd1);
      check_eq("done2", 32'(if2.done), 32'd1);
      check_eq("busy_at_done1", 32'(if1.busy), 32'd0);
      check_eq("busy_at_done2", 32'(if2.busy), 32'd0);
`ifdef FRAME_CAPTURE_CHECKSUM_EN
      check_eq("checksum1", 32'(if1.checksum), 32'(16'(sum1)));
      check_eq("checksum2", 32'(if2.checksum), 32'(16'(sum2)));
`endif
    end
    if (cyc == err_at) begin
      check_eq("err1", 32'(if1.err), 32'd1);
      check_eq("err2", 32'(if2.err), 32'd1);
      check_eq("busy_at_err", 32'(if1.busy), 32'd0);
      check_eq("done_at_err", 32'(if1.done), 32'd0);
    end
    if (cyc == lat_at) begin
      check_eq("latency1", 32'(if1.wr_en), 32'd1);
      check_eq("latency2", 32'(if2.wr_en), 32'd1);
    end
    if (cyc == rst_at) begin
      check_eq("rst_busy", 32'({if1.busy, if2.busy}), 32'd0);
      check_eq("rst_pulses", 32'({if1.done, if1.err, if2.done, if2.err}), 32'd0);
      check_eq("rst_wr_en", 32'({if1.wr_en, if2.wr_en}), 32'd0);
      check_eq("rst_wr_addr", 32'({if1.wr_addr, if2.wr_addr}), 32'd0);
      check_eq("rst_wr_data", 32'({if1.wr_data, if2.wr_data}), 32'd0);
`ifdef FRAME_CAPTURE_CHECKSUM_EN
      check_eq("rst_checksum", 32'({if1.checksum, if2.checksum}), 32'd0);
`endif
    end
    hs = h; vs = v; blank = bl; pix = p; st = s; rst = r;
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b1, 1'b1, 8'h00, (i == 0) ? s : 1'b0, 1'b0);
      if (i == 0 && s && ms == M_IDLE) ms = M_WAIT;
    end
  endtask

  // One frame: vsync, back porch, nl lines of len pixels, front porch.
  // start_mask bit y pulses start late in line y's hblank; rst_line resets there.
  task automatic send_frame(input int nl, input int len, input int start_mask,
                            input int rst_line, input bit ramp);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      if (i == 0) begin
        if (ms == M_CAP) begin
          err_at = cyc + 2; exp_err_n++; ms = M_IDLE;
        end else if (ms == M_WAIT) begin
          ms = M_CAP; a1 = 0; a2 = 0; sum1 = 0; sum2 = 0;
        end
      end
    end
    idle(2, 1'b0);
    for (int y = 0; y < nl; y++) begin
      for (int x = 0; x < len; x++) begin
        logic [7:0] p;
        p = ramp ? 8'(8 * y + x) : 8'($urandom);
        tick(1'b1, 1'b1, 1'b0, p, 1'b0, 1'b0);
        if (ms == M_CAP && x < int'(H)) begin
          exp1.push_back(16'({6'(a1), p})); a1++; sum1 += int'(p);
          if (x % 2 == 0 && y % 2 == 0) begin
            exp2.push_back(16'({6'(a2), p})); a2++; sum2 += int'(p);
          end
          if (x == 0 && y == 0) lat_at = cyc + 2;
        end
      end
      tick(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      if (ms == M_CAP && y == int'(V) - 1) begin
        done_at = cyc + 2; exp_done_n++; ms = M_IDLE;
      end
      tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, y == rst_line);
      if (y == rst_line) begin
        rst_at = cyc + 1; ms = M_IDLE;
      end
      tick(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 8'h00, ((start_mask >> y) & 1) != 0, 1'b0);
      if (((start_mask >> y) & 1) != 0 && ms == M_IDLE) ms = M_WAIT;
    end
    idle(3, 1'b0);
  endtask

  task automatic end_scenario();
    idle(4, 1'b0);
    check_eq("n_writes1", 32'(got1.size()), 32'(exp1.size()));
    check_eq("n_writes2", 32'(got2.size()), 32'(exp2.size()));
    for (int i = 0; i < exp1.size() && i < got1.size(); i++) check_eq("write1", 32'(got1[i]), 32'(exp1[i]));
    for (int i = 0; i < exp2.size() && i < got2.size(); i++) check_eq("write2", 32'(got2[i]), 32'(exp2[i]));
    check_eq("n_done1", 32'(n_done1), 32'(exp_done_n));
    check_eq("n_done2", 32'(n_done2), 32'(exp_done_n));
    check_eq("n_err1", 32'(n_err1), 32'(exp_err_n));
    check_eq("n_err2", 32'(n_err2), 32'(exp_err_n));
    exp1.delete(); exp2.delete(); got1.delete(); got2.delete();
  endtask

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1; blank = 1'b1; pix = 8'h00; st = 1'b0;
    // Reset state
    tick(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    rst_at = cyc + 1;
    idle(2, 1'b0);

    // Basic ramp frame: 32 writes data==addr, decimated copy 0,2,4,6,16,18,20,22
    idle(3, 1'b1);
    send_frame(4, 8, 0, -1, 1'b1);
    end_scenario();

    // Arming mid-frame, second start while busy ignored, no rearm afterwards
    send_frame(4, 8, 4'b1010, -1, 1'b0);
    send_frame(4, 8, 4'b0100, -1, 1'b0);
    send_frame(4, 8, 0, -1, 1'b0);
    end_scenario();

    // Short frame aborts at the next vsync, then a fresh capture works
    idle(3, 1'b1);
    send_frame(2, 8, 0, -1, 1'b0);
    send_frame(4, 8, 0, -1, 1'b0);
    idle(3, 1'b1);
    send_frame(4, 8, 0, -1, 1'b0);
    end_scenario();

    // Reset during line 2, then a normal capture from address 0
    idle(3, 1'b1);
    send_frame(4, 8, 0, 2, 1'b0);
    idle(3, 1'b1);
    send_frame(4, 8, 0, -1, 1'b0);
    end_scenario();

    // Overlong lines
    idle(3, 1'b1);
    send_frame(4, 10, 0, -1, 1'b0);
    end_scenario();

    // Random mix of frame heights, line lengths and start timing
    for (int k = 0; k < 10; k++) begin
      idle(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
      send_frame(($urandom_range(0, 3) == 0) ? 2 : 4, int'($urandom_range(8, 10)),
                 int'($urandom_range(0, 15)), -1, 1'b0);
    end
    end_scenario();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
